// File: rtl/delay_scheduler_if.sv
// delay_scheduler_if: requester-side request/duration inputs and grant/status outputs
interface delay_scheduler_if;
  logic [3:0] req;
  logic [7:0] dur0;
  logic [7:0] dur1;
  logic [7:0] dur2;
  logic [7:0] dur3;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       busy;
  logic [3:0] LED;
  modport master (output req, dur0, dur1, dur2, dur3, input gnt, done, busy, LED);
  modport slave (input req, dur0, dur1, dur2, dur3, output gnt, done, busy, LED);
endinterface

// File: rtl/delay_scheduler.sv
// delay_scheduler: round-robin arbiter sharing one unit/tick delay counter among four requesters
module delay_scheduler #(
  parameter int unsigned UNIT = 1000000
) (
  input logic              clk,
  input logic              rst_n,
  delay_scheduler_if.slave b
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [1:0]  ptr_q, win_q, win_d;
  logic [31:0] unit_cnt_q;
  logic [7:0]  tick_cnt_q, dur_q, dur_d;
  logic [3:0]  gnt_q, done_q, led_q;
  always_comb begin
    win_d = ptr_q;
    for (int k = 3; k >= 0; k--)
      if (b.req[ptr_q + 2'(k)]) win_d = ptr_q + 2'(k);
    dur_d = win_d == 2'd0 ? b.dur0 : win_d == 2'd1 ? b.dur1 : win_d == 2'd2 ? b.dur2 : b.dur3;
  end
  assign b.gnt  = gnt_q;
  assign b.done = done_q;
  assign b.busy = state_q != IDLE;
  assign b.LED  = led_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      unit_cnt_q <= '0;
      tick_cnt_q <= '0;
      dur_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      led_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (|b.req) begin
          win_q      <= win_d;
          dur_q      <= dur_d;
          gnt_q      <= 4'b0001 << win_d;
          unit_cnt_q <= '0;
          tick_cnt_q <= '0;
          state_q    <= dur_d == 8'd0 ? DONE : RUN;
          done_q     <= dur_d == 8'd0 ? 4'b0001 << win_d : 4'b0000;
        end
        // a dropped request aborts even on the edge that would have completed
        RUN: if (!b.req[win_q]) begin
          state_q <= IDLE;
          gnt_q   <= '0;
          ptr_q   <= win_q + 2'd1;
        end else if (unit_cnt_q == UNIT - 1) begin
          unit_cnt_q <= '0;
          tick_cnt_q <= tick_cnt_q + 8'd1;
          if (tick_cnt_q + 8'd1 == dur_q) begin
            state_q <= DONE;
            done_q  <= gnt_q;
          end
        end else unit_cnt_q <= unit_cnt_q + 32'd1;
        DONE: begin
          state_q <= IDLE;
          done_q  <= '0;
          gnt_q   <= '0;
          led_q   <= led_q ^ gnt_q;
          ptr_q   <= win_q + 2'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_delay_scheduler.sv
// tb_delay_scheduler: directed checks of grant timing, round-robin order, abort and reset with UNIT=4
module tb_delay_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int len, dat;
  logic [3:0] dval;
  delay_scheduler_if b ();
  delay_scheduler #(.UNIT(4)) dut (.clk(clk), .rst_n(rst_n), .b(b));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // length of the current grant, the cycle done pulsed in, and the done value seen
  task automatic run_grant(input logic clr);
    len = 0;
    dat = 0;
    dval = '0;
    while (b.gnt != 4'd0 && len < 100) begin
      len++;
      if (b.done != 4'd0) begin
        dat = len;
        dval = b.done;
        if (clr) b.req = 4'd0;
      end
      step();
    end
  endtask
  initial begin
    b.req = 4'd0;
    b.dur0 = 8'd0;
    b.dur1 = 8'd0;
    b.dur2 = 8'd0;
    b.dur3 = 8'd0;
    step();
    step();
    chk("rst_gnt", b.gnt, 4'd0);
    chk("rst_done", b.done, 4'd0);
    chk("rst_busy", b.busy, 1'b0);
    chk("rst_led", b.LED, 4'd0);
    rst_n = 1'b1;
    b.req = 4'b0001;
    b.dur0 = 8'd3;
    step();
    chk("s1_gnt", b.gnt, 4'b0001);
    chk("s1_busy", b.busy, 1'b1);
    run_grant(1'b1);
    chk("s1_len", len, 13);
    chk("s1_done_at", dat, 13);
    chk("s1_done", dval, 4'b0001);
    chk("s1_led", b.LED, 4'b0001);
    chk("s1_busy_end", b.busy, 1'b0);
    rst_n = 1'b0;
    step();
    chk("rst2_led", b.LED, 4'd0);
    rst_n = 1'b1;
    b.req = 4'b1111;
    b.dur0 = 8'd1;
    b.dur1 = 8'd1;
    b.dur2 = 8'd1;
    b.dur3 = 8'd1;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("s2_gnt%0d", k), b.gnt, 32'd1 << (k % 4));
      run_grant(k == 4);
      chk($sformatf("s2_len%0d", k), len, 5);
      chk($sformatf("s2_done%0d", k), dval, 32'd1 << (k % 4));
      chk($sformatf("s2_idle%0d", k), b.busy, 1'b0);
      if (k < 4) step();
    end
    chk("s2_led", b.LED, 4'b1110);
    b.req = 4'b0100;
    b.dur2 = 8'd0;
    step();
    chk("s3_gnt", b.gnt, 4'b0100);
    chk("s3_done", b.done, 4'b0100);
    run_grant(1'b1);
    chk("s3_len", len, 1);
    chk("s3_led", b.LED, 4'b1010);
    b.req = 4'b0010;
    b.dur1 = 8'd5;
    step();
    chk("s4_gnt", b.gnt, 4'b0010);
    repeat (7) step();
    chk("s4_run_gnt", b.gnt, 4'b0010);
    chk("s4_run_busy", b.busy, 1'b1);
    b.req = 4'd0;
    step();
    chk("s4_abort_gnt", b.gnt, 4'd0);
    chk("s4_abort_busy", b.busy, 1'b0);
    chk("s4_abort_done", b.done, 4'd0);
    chk("s4_abort_led", b.LED, 4'b1010);
    b.req = 4'b0011;
    b.dur0 = 8'd2;
    step();
    chk("s4_ptr_gnt", b.gnt, 4'b0001);
    b.dur0 = 8'd9;
    run_grant(1'b0);
    chk("s6_len", len, 9);
    chk("s6_done_at", dat, 9);
    chk("s6_done", dval, 4'b0001);
    chk("s6_led", b.LED, 4'b1011);
    step();
    chk("s6_next_gnt", b.gnt, 4'b0010);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("s5_rst_gnt", b.gnt, 4'd0);
    chk("s5_rst_busy", b.busy, 1'b0);
    chk("s5_rst_done", b.done, 4'd0);
    chk("s5_rst_led", b.LED, 4'd0);
    rst_n = 1'b1;
    step();
    chk("s5_regrant", b.gnt, 4'b0001);
    b.req = 4'd0;
    step();
    chk("s7_abort_gnt", b.gnt, 4'd0);
    b.req = 4'b0001;
    b.dur0 = 8'd0;
    step();
    chk("s7_done", b.done, 4'b0001);
    rst_n = 1'b0;
    b.req = 4'd0;
    step();
    chk("s7_led", b.LED, 4'd0);
    chk("s7_gnt", b.gnt, 4'd0);
    rst_n = 1'b1;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/delay_scheduler.md
DELAY_SCHEDULER -- requirements
Module: delay_scheduler

Interface
REQ-001 Parameter UNIT, default 1000000, SHALL set the clock cycles per delay unit (10 ms at 100 MHz); legal range is 1 to 2^32-1.
REQ-002 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 req  input  4  SHALL carry the per-requester delay request, bit i for requester i, level-sensitive.
REQ-005 dur0, dur1, dur2, dur3  input  8 each  SHALL give each requester's delay length in units, 0..255.
REQ-006 gnt  output  4  SHALL be the one-hot grant of the shared delay counter; all zero when no requester owns it.
REQ-007 done  output  4  SHALL carry a one-cycle completion pulse on the bit of the requester that finished.
REQ-008 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-009 LED  output  4  SHALL toggle bit i on each completed delay of requester i.

Function
REQ-010 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 IDLE: if req is nonzero at an edge, the FSM SHALL pick the winner round-robin, starting at pointer ptr and ascending modulo 4.
REQ-012 On that edge it SHALL also latch the winner's dur into dur_q, set the winner's gnt bit, and clear unit_cnt (32 bit) and tick_cnt (8 bit).
REQ-013 That edge SHALL enter RUN if the latched dur is nonzero, and DONE directly if it is 0.
REQ-014 RUN: unit_cnt SHALL increment each cycle; at UNIT-1 it SHALL wrap to 0 and tick_cnt SHALL increment.
REQ-015 RUN SHALL go to DONE on the edge where tick_cnt would reach dur_q; a delay of D is exactly D*UNIT cycles in RUN.
REQ-016 DONE SHALL last exactly one cycle, with done[w] high and gnt[w] still high.
REQ-017 On exiting DONE, the FSM SHALL toggle LED[w], set ptr to (w+1) mod 4, clear gnt and return to IDLE.
REQ-018 Timing: gnt SHALL be high for D*UNIT+1 cycles.
REQ-019 Timing: done SHALL pulse in the last of those gnt cycles.
REQ-020 Timing: there SHALL be at least one IDLE cycle between grants.
REQ-021 Abort: if req[w] is low at any RUN edge, the FSM SHALL go to IDLE without a done pulse and without toggling LED.
REQ-022 Abort: on that return to IDLE, ptr SHALL advance to (w+1) mod 4.
REQ-023 Changes to dur inputs after a grant SHALL be ignored until the next grant.
REQ-024 A requester still requesting after DONE SHALL be re-granted only after every other pending requester has been served once.
REQ-025 Requests arriving from any requester while busy SHALL be held pending (level) and arbitrated at the next IDLE; none SHALL be lost while req stays high.
REQ-026 gnt SHALL never have more than one bit set, and done SHALL never have more than one bit set.

Reset
REQ-027 When rst_n is low at an edge, the block SHALL enter IDLE with gnt=0, done=0, busy=0, LED=0, ptr=0, unit_cnt=0, tick_cnt=0 and dur_q=0.
REQ-028 Reset SHALL take priority over every other event, including mid-RUN and in DONE.
REQ-029 A reset asserted during DONE SHALL suppress that cycle's LED toggle.
REQ-030 The first rising edge with rst_n high SHALL evaluate IDLE normally.

Verification (UNIT=4)
REQ-031 Scenario: req=0001, dur0=3 -> gnt=0001 for 13 cycles, done=0001 on the 13th, then LED=0001 and busy=0.
REQ-032 Scenario: req=1111 held, all dur=1 -> grants in order 0,1,2,3,0; each lasts 5 cycles with 1 IDLE cycle between.
REQ-033 Scenario: req=0100, dur2=0 -> gnt=0100 and done=0100 in the same single cycle, then LED=0100.
REQ-034 Scenario: req=0010, dur1=5; drop req[1] after 8 RUN cycles -> IDLE next edge, no done pulse, LED unchanged, ptr=2.
REQ-035 Scenario: rst_n low for 1 cycle mid-RUN -> all outputs 0 next edge; a held req is re-granted on the following edge starting from requester 0.
REQ-036 Scenario: req=0011, dur0=2; change dur0 to 9 during RUN -> done still after 8 RUN cycles, then requester 1 is granted.
